// File: rtl/matrix_op_defs_pkg.sv
// rtl/matrix_op_defs_pkg.sv - shared matrix operation types, widths and defaults
package matrix_op_defs_pkg;

  localparam int MATRIX_ADDR_WIDTH         = 12;
  localparam int MATRIX_DATA_WIDTH         = 16;
  localparam int MATRIX_OP_TIMEOUT_DEFAULT = 65536;

  typedef enum logic [2:0] {
    MATRIX_OP_STATUS_SUCCESS     = 3'd0,
    MATRIX_OP_STATUS_ERR_DIM     = 3'd1,
    MATRIX_OP_STATUS_ERR_OP      = 3'd2,
    MATRIX_OP_STATUS_ERR_TIMEOUT = 3'd3
  } matrix_op_status_e;

  typedef enum logic [1:0] {
    MATRIX_OP_SEL_ADD       = 2'd0,
    MATRIX_OP_SEL_MUL       = 2'd1,
    MATRIX_OP_SEL_TRANSPOSE = 2'd2,
    MATRIX_OP_SEL_SCALAR    = 2'd3
  } matrix_op_sel_e;

endpackage

// File: rtl/matrix_op_port_mux.sv
// rtl/matrix_op_port_mux.sv - routes the selected unit onto the shared BRAM read port and writer
module matrix_op_port_mux
  import matrix_op_defs_pkg::*;
#(
  parameter int NUM_OPS = 4
) (
  input  logic                         grant,
  input  logic [2:0]                   sel,
  input  logic [NUM_OPS-1:0]           op_busy,
  input  matrix_op_status_e            op_status [NUM_OPS],
  input  logic [MATRIX_ADDR_WIDTH-1:0] op_read_addr [NUM_OPS],
  input  logic [NUM_OPS-1:0]           op_write_request,
  input  logic [NUM_OPS-1:0]           op_data_valid,
  input  logic [2:0]                   op_matrix_id [NUM_OPS],
  input  logic [7:0]                   op_actual_rows [NUM_OPS],
  input  logic [7:0]                   op_actual_cols [NUM_OPS],
  input  logic [7:0][7:0]              op_matrix_name [NUM_OPS],
  input  logic [MATRIX_DATA_WIDTH-1:0] op_data_in [NUM_OPS],
  input  logic                         write_ready,
  input  logic                         writer_ready,
  input  logic                         write_done,
  output logic                         sel_busy,
  output matrix_op_status_e            sel_status,
  output logic [MATRIX_ADDR_WIDTH-1:0] read_addr,
  output logic                         write_request,
  output logic [2:0]                   matrix_id,
  output logic [7:0]                   actual_rows,
  output logic [7:0]                   actual_cols,
  output logic [7:0][7:0]              matrix_name,
  output logic [MATRIX_DATA_WIDTH-1:0] data_in,
  output logic                         data_valid,
  output logic [NUM_OPS-1:0]           op_write_ready,
  output logic [NUM_OPS-1:0]           op_writer_ready,
  output logic [NUM_OPS-1:0]           op_write_done
);

  // Loop compare keeps an out-of-range sel (invalid opcode) from indexing past the unit arrays
  always_comb begin
    sel_busy        = 1'b0;
    sel_status      = MATRIX_OP_STATUS_SUCCESS;
    read_addr       = '0;
    write_request   = 1'b0;
    matrix_id       = '0;
    actual_rows     = '0;
    actual_cols     = '0;
    matrix_name     = '0;
    data_in         = '0;
    data_valid      = 1'b0;
    op_write_ready  = '0;
    op_writer_ready = '0;
    op_write_done   = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (sel == 3'(i)) begin
        sel_busy   = op_busy[i];
        sel_status = op_status[i];
        if (grant) begin
          read_addr          = op_read_addr[i];
          write_request      = op_write_request[i];
          matrix_id          = op_matrix_id[i];
          actual_rows        = op_actual_rows[i];
          actual_cols        = op_actual_cols[i];
          matrix_name        = op_matrix_name[i];
          data_in            = op_data_in[i];
          data_valid         = op_data_valid[i];
          op_write_ready[i]  = write_ready;
          op_writer_ready[i] = writer_ready;
          op_write_done[i]   = write_done;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_op_dispatcher.sv
// rtl/matrix_op_dispatcher.sv - launches one matrix op unit per command and grants it the shared ports
module matrix_op_dispatcher
  import matrix_op_defs_pkg::*;
#(
  parameter int NUM_OPS        = 4,
  parameter int TIMEOUT_CYCLES = MATRIX_OP_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [2:0]                   cmd_a_id,
  input  logic [2:0]                   cmd_b_id,
  output logic                         busy,
  output logic                         done,
  output matrix_op_status_e            result_status,
  output logic [2:0]                   result_op,
  output logic [NUM_OPS-1:0]           op_start,
  output logic [2:0]                   op_a_id,
  output logic [2:0]                   op_b_id,
  input  logic [NUM_OPS-1:0]           op_busy,
  input  matrix_op_status_e            op_status [NUM_OPS],
  input  logic [MATRIX_ADDR_WIDTH-1:0] op_read_addr [NUM_OPS],
  output logic [MATRIX_ADDR_WIDTH-1:0] read_addr,
  input  logic [NUM_OPS-1:0]           op_write_request,
  input  logic [NUM_OPS-1:0]           op_data_valid,
  input  logic [2:0]                   op_matrix_id [NUM_OPS],
  input  logic [7:0]                   op_actual_rows [NUM_OPS],
  input  logic [7:0]                   op_actual_cols [NUM_OPS],
  input  logic [7:0][7:0]              op_matrix_name [NUM_OPS],
  input  logic [MATRIX_DATA_WIDTH-1:0] op_data_in [NUM_OPS],
  output logic                         write_request,
  output logic [2:0]                   matrix_id,
  output logic [7:0]                   actual_rows,
  output logic [7:0]                   actual_cols,
  output logic [7:0][7:0]              matrix_name,
  output logic [MATRIX_DATA_WIDTH-1:0] data_in,
  output logic                         data_valid,
  input  logic                         write_ready,
  input  logic                         writer_ready,
  input  logic                         write_done,
  output logic [NUM_OPS-1:0]           op_write_ready,
  output logic [NUM_OPS-1:0]           op_writer_ready,
  output logic [NUM_OPS-1:0]           op_write_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_REPORT
  } state_e;

  localparam int                 CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_OPS-1:0] ONE_HOT0 = NUM_OPS'(1);

  state_e            state;
  logic [2:0]        sel;
  logic [CNT_W-1:0]  tcnt;
  logic              grant;
  logic              sel_busy;
  matrix_op_status_e sel_status;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign grant     = (state == S_LAUNCH) || (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);

  // Command sequencing; op_start and done are registered so they line up with LAUNCH and REPORT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sel           <= '0;
      op_a_id       <= '0;
      op_b_id       <= '0;
      tcnt          <= '0;
      op_start      <= '0;
      done          <= 1'b0;
      result_status <= MATRIX_OP_STATUS_SUCCESS;
      result_op     <= '0;
    end else begin
      op_start <= '0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sel     <= cmd_op;
            op_a_id <= cmd_a_id;
            op_b_id <= cmd_b_id;
            if (int'(cmd_op) >= NUM_OPS) begin
              result_status <= MATRIX_OP_STATUS_ERR_OP;
              result_op     <= cmd_op;
              done          <= 1'b1;
              state         <= S_REPORT;
            end else begin
              op_start <= ONE_HOT0 << cmd_op;
              state    <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          tcnt  <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == CNT_LAST) begin
            result_status <= MATRIX_OP_STATUS_ERR_TIMEOUT;
            result_op     <= sel;
            done          <= 1'b1;
            state         <= S_REPORT;
          end else if (sel_busy) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          tcnt <= tcnt + 1'b1;
          // Completion is checked first so it wins over a coincident timeout
          if (!sel_busy) begin
            result_status <= sel_status;
            result_op     <= sel;
            done          <= 1'b1;
            state         <= S_REPORT;
          end else if (tcnt == CNT_LAST) begin
            result_status <= MATRIX_OP_STATUS_ERR_TIMEOUT;
            result_op     <= sel;
            done          <= 1'b1;
            state         <= S_REPORT;
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  matrix_op_port_mux #(
    .NUM_OPS(NUM_OPS)
  ) u_port_mux (
    .grant           (grant),
    .sel             (sel),
    .op_busy         (op_busy),
    .op_status       (op_status),
    .op_read_addr    (op_read_addr),
    .op_write_request(op_write_request),
    .op_data_valid   (op_data_valid),
    .op_matrix_id    (op_matrix_id),
    .op_actual_rows  (op_actual_rows),
    .op_actual_cols  (op_actual_cols),
    .op_matrix_name  (op_matrix_name),
    .op_data_in      (op_data_in),
    .write_ready     (write_ready),
    .writer_ready    (writer_ready),
    .write_done      (write_done),
    .sel_busy        (sel_busy),
    .sel_status      (sel_status),
    .read_addr       (read_addr),
    .write_request   (write_request),
    .matrix_id       (matrix_id),
    .actual_rows     (actual_rows),
    .actual_cols     (actual_cols),
    .matrix_name     (matrix_name),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .op_write_ready  (op_write_ready),
    .op_writer_ready (op_writer_ready),
    .op_write_done   (op_write_done)
  );

endmodule

// File: doc/matrix_op_dispatcher.md
Name: matrix_op_dispatcher

Overview:
Command-level controller that sequences the matrix operation units (add, mul, transpose, scalar, …). It accepts one command at a time, pulses `start` into the selected unit, and grants that unit exclusive use of the shared BRAM read port and the shared matrix writer. It waits for the unit to finish, then reports status. It sits between the top-level UI/command FSM and the bank of `matrix_op_*` units.

Parameters:
- NUM_OPS, 4: number of attached op units; unit index = opcode.
- TIMEOUT_CYCLES, 65536: maximum cycles a launched unit may take before the dispatcher aborts the grant.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  dispatcher idle and able to accept.
- cmd_op  in  3  opcode; a value ≥ NUM_OPS is invalid.
- cmd_a_id, cmd_b_id  in  3 each  operand matrix IDs.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- result_status  out  matrix_op_status_e  status of the last command.
- result_op  out  3  opcode of the last command.
- op_start  out  NUM_OPS  per-unit start pulse.
- op_a_id, op_b_id  out  3 each  latched IDs, broadcast to all units.
- op_busy  in  NUM_OPS  per-unit busy.
- op_status  in  matrix_op_status_e[NUM_OPS]  per-unit status.
- op_read_addr  in  MATRIX_ADDR_WIDTH[NUM_OPS]  unit read addresses.
- read_addr  out  MATRIX_ADDR_WIDTH  to the shared BRAM.
- op_write_request, op_data_valid  in  NUM_OPS each  unit writer requests.
- op_matrix_id  in  3[NUM_OPS]  unit target matrix ID.
- op_actual_rows, op_actual_cols  in  8[NUM_OPS]  unit result dimensions.
- op_matrix_name  in  8[NUM_OPS][8]  unit result name.
- op_data_in  in  MATRIX_DATA_WIDTH[NUM_OPS]  unit result data.
- write_request, matrix_id, actual_rows, actual_cols, matrix_name, data_in, data_valid  out  to the writer (same widths as the unit side).
- write_ready, writer_ready, write_done  in  1 each  from the writer.
- op_write_ready, op_writer_ready, op_write_done  out  NUM_OPS each  writer feedback routed to units.

Behaviour:
- Reset values:
  - state IDLE, so cmd_ready=1 and busy=0.
  - done=0, result_status=MATRIX_OP_STATUS_SUCCESS, result_op=0.
  - op_start=0, op_a_id/op_b_id=0, grant inactive, timeout counter 0.
- Reset mid-operation returns to IDLE immediately and drops the grant. Units are not otherwise notified.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, REPORT.
- IDLE:
  - cmd_ready = (state==IDLE), combinational.
  - On cmd_valid, latch op and IDs.
  - Opcode ≥ NUM_OPS: go to REPORT with MATRIX_OP_STATUS_ERR_OP.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - op_start[sel]=1 for exactly this one cycle; all other bits 0.
  - Grant becomes active. Clear the counter. Go to WAIT_BUSY.
- WAIT_BUSY: when op_busy[sel]=1, go to WAIT_DONE.
- WAIT_DONE: when op_busy[sel]=0, capture op_status[sel] into result_status and go to REPORT.
- Timeout:
  - The counter increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 and completion has not been seen in that cycle, go to REPORT with MATRIX_OP_STATUS_ERR_TIMEOUT.
  - If completion and timeout occur in the same cycle, completion wins.
- REPORT:
  - done=1 for one cycle; grant released; go to IDLE.
  - result_status and result_op hold until the next REPORT.
- Latency:
  - Invalid-op done arrives in the cycle after the accept edge.
  - Valid op: op_start is in cycle 1 after accept; done is 1 cycle after op_busy[sel] falls.
- Grant mux (combinational, zero latency, active LAUNCH..WAIT_DONE):
  - read_addr = op_read_addr[sel]; otherwise 0.
  - Writer outputs = selected unit's signals; write_request and data_valid are forced to 0 when the grant is inactive.
  - op_write_ready, op_writer_ready and op_write_done are driven only at index sel; all others are 0.
- cmd_valid asserted while not IDLE is ignored (not accepted) until IDLE.

Decomposition:
- matrix_op_defs_pkg additions:
  - enum values MATRIX_OP_STATUS_ERR_OP and MATRIX_OP_STATUS_ERR_TIMEOUT.
  - typedef matrix_op_sel_e (MATRIX_OP_SEL_ADD=0, MUL=1, TRANSPOSE=2, SCALAR=3).
  - constant MATRIX_OP_TIMEOUT_DEFAULT.
- Sub-module matrix_op_port_mux: purely combinational, NUM_OPS-way read/writer routing with grant gating.

Test Plan:
1. Reset: cmd_ready=1, busy=0, done=0, op_start=0, read_addr=0, write_request=0.
2. cmd op=0 A=1 B=2, with a real add unit on slot 0:
   - op_start[0] is high exactly one cycle, in cycle 1 after accept.
   - Only op_write_ready[0] toggles.
   - Block 0 data = 11,22,33,44.
   - done pulses with result_status=SUCCESS, result_op=0.
3. cmd op=1 with a slot-1 stub returning ERR_DIM after 5 busy cycles: result_status=ERR_DIM, op_start[0] never asserted, write_request stays 0.
4. cmd_op=5 (NUM_OPS=4): done in the cycle after accept, status ERR_OP, op_start stays 0.
5. TIMEOUT_CYCLES=64 with a slot-2 stub that never raises busy: done after 64 wait cycles with ERR_TIMEOUT, grant dropped, and the next valid command is accepted normally.
6. Overlap and reset:
   - cmd_valid held high during a running op: not accepted until IDLE (cmd_ready=0 throughout).
   - rst_n pulsed low in WAIT_DONE: all outputs are at reset values in the same cycle.
